// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//   Serial frame transmitter for the single-wire link. Accepts one parallel
//   request (address, length, payload) while idle and shifts it out on one
//   line. Every line change is launched on the rising edge of CLK, so the
//   line is stable at the falling edge, where the receiver samples it.
//
//   Frame on the line: start bit (0), addr LSB first, len LSB first,
//   len payload bits (data[0] first), optional even-parity bit, stop bit (1).
//
//   Optional feature macro: SERIAL_TX_PARITY_EN
//     defined   -> one even-parity bit (over addr, len and the sent payload
//                  bits) is inserted before the stop bit.
//     undefined -> no parity bit. The paired receiver must match.
//
// Ports
//   CLK     in   1       clock, all state updates on posedge
//   RST     in   1       asynchronous, active-high reset
//   start   in   1       frame request, sampled only while ready=1
//   addr    in   ADDR_W  address field, captured on accepted start
//   len     in   LEN_W   payload bit count, captured on accepted start
//   data    in   DATA_W  payload, data[0] sent first, bits >= len ignored
//   serOut  out  1       serial line, idles high (registered)
//   ready   out  1       high only while idle (registered)
//   busy    out  1       high from the start bit through the stop bit
//   done    out  1       one-cycle pulse during the stop bit
// ---------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 6,
  parameter int DATA_W = 63   // must equal 2**LEN_W - 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              serOut,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_LEN   = 3'd3,
    ST_DATA  = 3'd4,
    ST_PAR   = 3'd5,
    ST_STOP  = 3'd6
  } state_e;

  // State entered after the last payload bit (or after LEN when len=0).
`ifdef SERIAL_TX_PARITY_EN
  localparam state_e ST_TAIL = ST_PAR;
`else
  localparam state_e ST_TAIL = ST_STOP;
`endif

  localparam logic [LEN_W-1:0] ADDR_LAST = LEN_W'(ADDR_W - 1);
  localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(LEN_W - 1);
  localparam logic [LEN_W-1:0] CNT_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);

`ifdef SERIAL_TX_PARITY_EN
  // Even parity over the address, the length and only the payload bits that
  // are actually transmitted (index below l).
  function automatic logic frame_parity(
    input logic [ADDR_W-1:0] a,
    input logic [LEN_W-1:0]  l,
    input logic [DATA_W-1:0] d
  );
    logic p;
    p = (^a) ^ (^l);
    for (int i = 0; i < DATA_W; i++) begin
      p = p ^ ((LEN_W'(i) < l) ? d[i] : 1'b0);
    end
    return p;
  endfunction
`endif

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q,   cnt_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [LEN_W-1:0]    len_q,   len_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                ser_q,   ser_d;
  logic                ready_q, ready_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  // State, counter, shadow and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      addr_q  <= {ADDR_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      ser_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, bit counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = addr;
          len_d   = len;
          data_d  = data;
          cnt_d   = CNT_ZERO;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_LEN;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_ADDR;
        end
      end
      ST_LEN: begin
        if (cnt_q == LEN_LAST) begin
          cnt_d = CNT_ZERO;
          // A zero-length frame skips the payload entirely.
          if (len_q == CNT_ZERO) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        // len_q >= 1 here, so len_q-1 never underflows and cnt stays <= 62.
        if (cnt_q == (len_q - CNT_ONE)) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_TAIL;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_DATA;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PAR: begin
        state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the outputs come straight out of
  // flops and line up with the state they describe.
  always_comb begin
    ser_d   = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_IDLE: begin
        ser_d   = 1'b1;
        ready_d = 1'b1;
      end
      ST_START: begin
        ser_d  = 1'b0;
        busy_d = 1'b1;
      end
      ST_ADDR: begin
        ser_d  = |(addr_d & (ADDR_W'(1) << cnt_d));
        busy_d = 1'b1;
      end
      ST_LEN: begin
        ser_d  = |(len_d & (LEN_W'(1) << cnt_d));
        busy_d = 1'b1;
      end
      ST_DATA: begin
        ser_d  = |(data_d & (DATA_W'(1) << cnt_d));
        busy_d = 1'b1;
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PAR: begin
        ser_d  = frame_parity(addr_d, len_d, data_d);
        busy_d = 1'b1;
      end
`endif
      ST_STOP: begin
        ser_d  = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        ser_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign serOut = ser_q;
  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//   Self-checking bench for serial_frame_tx: table-driven frames, hand-written
//   reset/abort/ignored-request sequences and randomized frames, all compared
//   with a frame-building reference model (bit list built from the field
//   rules). Honors SERIAL_TX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  addr_i;
  logic [5:0]  len_i;
  logic [62:0] data_i;
  logic        ser_o, ready_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit got_q[$];

  typedef struct {
    logic [5:0]  addr;
    logic [5:0]  len;
    logic [62:0] data;
    bit          hold;
    bit          scram;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  serial_frame_tx dut (
    .CLK    (clk),
    .RST    (rst),
    .start  (start_i),
    .addr   (addr_i),
    .len    (len_i),
    .data   (data_i),
    .serOut (ser_o),
    .ready  (ready_o),
    .busy   (busy_o),
    .done   (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the expected line sequence of one frame.
  function automatic void build_frame(input logic [5:0] a, input logic [5:0] l,
                                      input logic [62:0] d);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin exp_q.push_back(a[i]); ones += int'(a[i]); end
    for (int i = 0; i < 6; i++) begin exp_q.push_back(l[i]); ones += int'(l[i]); end
    for (int i = 0; i < int'(l); i++) begin exp_q.push_back(d[i]); ones += int'(d[i]); end
`ifdef SERIAL_TX_PARITY_EN
    exp_q.push_back((ones % 2) == 1);
`endif
    exp_q.push_back(1'b1);
  endfunction

  // Sends one frame from an IDLE sample point and returns at the next IDLE
  // sample point. Measures busy length and done position from the DUT.
  task automatic run_frame(input logic [5:0] a, input logic [5:0] l, input logic [62:0] d,
                           input bit hold, input bit scram,
                           output int n, output int done_idx);
    int w, dn;
    build_frame(a, l, d);
    got_q.delete();
    w = 0;
    while (ready_o !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) chk("ready_wait", 64'(ready_o), 64'd1);
    addr_i = a; len_i = l; data_i = d; start_i = 1'b1;
    @(posedge clk); #1;
    n = 0; dn = 0; done_idx = -1;
    while (busy_o === 1'b1 && n < 120) begin
      got_q.push_back(ser_o);
      chk("ready_low_busy", 64'(ready_o), 64'd0);
      if (done_o === 1'b1) begin
        dn++;
        if (done_idx < 0) done_idx = n;
        start_i = hold;
      end else if (scram && !hold) begin
        start_i = 1'($urandom_range(0, 1));
      end else begin
        start_i = hold;
      end
      if (scram) begin
        addr_i = 6'($urandom); len_i = 6'($urandom); data_i = {31'($urandom), 32'($urandom)};
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 120) chk("frame_timeout", 64'(n), 64'(exp_q.size()));
    chk("frame_len_model", 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) chk($sformatf("bit%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      else checks++;
    end
    chk("done_count", 64'(dn), 64'd1);
    chk("idle_ser", 64'(ser_o), 64'd1);
    chk("idle_ready", 64'(ready_o), 64'd1);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_done", 64'(done_o), 64'd0);
  endtask

  initial begin
    bit basic_ref[$];
    int n, di, sum;
    logic [5:0]  ra, rl;
    logic [62:0] rd;
    bit rh, rs;

    basic_ref = '{1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,
                  1'b1,1'b1,1'b0,1'b1, 1'b1};
`ifdef SERIAL_TX_PARITY_EN
    basic_ref.insert(17, 1'b1);
`endif

    vecs[0] = '{6'h25, 6'd4,  63'b1011, 1'b0, 1'b0, 18 + PX};
    vecs[1] = '{6'h00, 6'd0,  63'd0, 1'b0, 1'b0, 14 + PX};
    vecs[2] = '{6'h3F, 6'd63, {63{1'b1}}, 1'b1, 1'b1, 77 + PX};
    vecs[3] = '{6'h3F, 6'd63, 63'h2AAA_AAAA_5555_5555, 1'b0, 1'b1, 77 + PX};
    vecs[4] = '{6'h2A, 6'd1,  63'd1, 1'b0, 1'b1, 15 + PX};
    vecs[5] = '{6'h15, 6'd32, 63'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 46 + PX};
    vecs[6] = '{6'h01, 6'd62, {63{1'b1}}, 1'b0, 1'b0, 76 + PX};

    // Reset values, then a quiet line with start low.
    rst = 1'b1; start_i = 1'b0; addr_i = 6'd0; len_i = 6'd0; data_i = 63'd0;
    #12;
    chk("rst_ser", 64'(ser_o), 64'd1);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      chk("quiet_ser", 64'(ser_o), 64'd1);
      chk("quiet_ready", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
    end

    // Table: fixed frames incl. basic, zero length, max length back-to-back.
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].hold, vecs[v].scram, n, di);
      chk($sformatf("vec%0d_cycles", v), 64'(n), 64'(vecs[v].exp_cycles));
      chk($sformatf("vec%0d_done_at", v), 64'(di), 64'(vecs[v].exp_cycles - 1));
      if (v == 0) begin
        chk("basic_size", 64'(got_q.size()), 64'(basic_ref.size()));
        for (int i = 0; i < got_q.size() && i < basic_ref.size(); i++)
          chk($sformatf("basic_bit%0d", i), 64'(got_q[i]), 64'(basic_ref[i]));
      end
      if (v == 1) begin
        sum = 0;
        foreach (got_q[i]) sum += int'(got_q[i]);
        chk("zero_ones", 64'(sum), 64'd1);
        if (got_q.size() > 0) chk("zero_last", 64'(got_q[got_q.size()-1]), 64'd1);
        else chk("zero_last", 64'd0, 64'd1);
      end
    end
    start_i = 1'b0;

    // Ignored request: start pulsed while busy, then no extra frame.
    run_frame(6'h0C, 6'd9, 63'h1F3, 1'b0, 1'b1, n, di);
    chk("ign_cycles", 64'(n), 64'(23 + PX));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("ign_no_frame_ser", 64'(ser_o), 64'd1);
      chk("ign_no_frame_busy", 64'(busy_o), 64'd0);
    end

    // Abort during the 3rd payload bit (frame index 15).
    build_frame(6'h11, 6'd10, 63'h3B5);
    addr_i = 6'h11; len_i = 6'd10; data_i = 63'h3B5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    chk("abort_pre_busy", 64'(busy_o), 64'd1);
    chk("abort_pre_bit", 64'(ser_o), 64'(exp_q[15]));
    rst = 1'b1;
    #1;
    chk("abort_ser", 64'(ser_o), 64'd1);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_done", 64'(done_o), 64'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done_o), 64'd0);
      chk("abort_idle_ser", 64'(ser_o), 64'd1);
    end
    run_frame(6'h11, 6'd10, 63'h3B5, 1'b0, 1'b0, n, di);
    chk("post_abort_cycles", 64'(n), 64'(24 + PX));

    // Randomized frames against the model.
    for (int r = 0; r < 20; r++) begin
      ra = 6'($urandom); rl = 6'($urandom_range(0, 63));
      rd = {31'($urandom), 32'($urandom)};
      rh = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      run_frame(ra, rl, rd, rh, rs, n, di);
      chk("rand_cycles", 64'(n), 64'(14 + int'(rl) + PX));
      chk("rand_done_at", 64'(di), 64'(13 + int'(rl) + PX));
    end
    start_i = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
